// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// ex_stage -- execute stage of the 5-stage pipelined 64-bit CPU.
//
// Computes the ALU result (with NZCV flags), the barrel-shifter result and a
// 64-bit iterative shift-add multiply. Registers everything the memory-access
// stage consumes into the *_Ex buffers. While a multiply is iterating, Stall
// holds the upstream pipeline and bubbles are pushed downstream.
//
// Ports
//   clk, reset         : single clock, synchronous active-high reset
//   DataA_Reg/DataB_Reg: forwarded operands (DataB is also store data)
//   Imm_Reg, ALUSrc_Reg: immediate and ALU B-operand select
//   ALUOp_Reg          : 000 pass B, 010 add, 011 sub, 100 and, 101 or, 110 xor
//   SHAMT_Reg,
//   ShiftDir_Reg       : shift amount, 0 = logical left / 1 = logical right
//   SetFlags_Reg       : update NZCV when the instruction is accepted
//   MemWrite_Reg, MemRead_Reg, RegWrite_Reg, RegWrSrc_Reg, Rd_Reg : controls
//   *_Ex               : registered results/controls for the memory stage
//   Flags              : registered {N,Z,C,V}
//   Stall              : combinational hold request to the upstream stages
// -----------------------------------------------------------------------------
module ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] DataA_Reg,
    input  logic [63:0] DataB_Reg,
    input  logic [63:0] Imm_Reg,
    input  logic        ALUSrc_Reg,
    input  logic [2:0]  ALUOp_Reg,
    input  logic [5:0]  SHAMT_Reg,
    input  logic        ShiftDir_Reg,
    input  logic        SetFlags_Reg,
    input  logic        MemWrite_Reg,
    input  logic        MemRead_Reg,
    input  logic        RegWrite_Reg,
    input  logic [1:0]  RegWrSrc_Reg,
    input  logic [4:0]  Rd_Reg,
    output logic [63:0] ALU_out_Ex,
    output logic [63:0] shifter2_out_Ex,
    output logic [63:0] MUL_out_Ex,
    output logic [63:0] DataB_Ex,
    output logic        MemWrite_Ex,
    output logic        MemRead_Ex,
    output logic        RegWrite_Ex,
    output logic [1:0]  RegWrSrc_Ex,
    output logic [4:0]  Rd_Ex,
    output logic [3:0]  Flags,
    output logic        Stall
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mul_state_t;

    localparam logic [1:0] WB_SRC_MUL = 2'b01;
    localparam logic [4:0] RD_NONE    = 5'd31;

    mul_state_t  state, state_next;
    logic [63:0] mul_a;     // multiplicand, shifted left one place per iteration
    logic [63:0] mul_b;     // multiplier, shifted right so bit 0 is the current bit
    logic [63:0] mul_acc;
    logic [5:0]  mul_cnt;

    logic        is_mul;
    logic [63:0] alu_b;
    logic [64:0] add_sum;
    logic [64:0] sub_sum;
    logic [63:0] alu_result;
    logic        alu_c;
    logic        alu_v;
    logic [3:0]  alu_flags;
    logic [63:0] shift_result;

    assign is_mul = RegWrite_Reg && (RegWrSrc_Reg == WB_SRC_MUL);

    // ------------------------------------------------------------------ ALU
    assign alu_b   = ALUSrc_Reg ? Imm_Reg : DataB_Reg;
    assign add_sum = {1'b0, DataA_Reg} + {1'b0, alu_b};
    // Subtract as A + ~B + 1 so bit 64 is the ARM-style carry (1 = no borrow).
    assign sub_sum = {1'b0, DataA_Reg} + {1'b0, ~alu_b} + 65'd1;

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        alu_result = '0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        case (ALUOp_Reg)
            3'b000: alu_result = alu_b;
            3'b010: begin
                alu_result = add_sum[63:0];
                alu_c      = add_sum[64];
                alu_v      = (DataA_Reg[63] == alu_b[63]) &&
                             (add_sum[63] != DataA_Reg[63]);
            end
            3'b011: begin
                alu_result = sub_sum[63:0];
                alu_c      = sub_sum[64];
                alu_v      = (DataA_Reg[63] != alu_b[63]) &&
                             (sub_sum[63] != DataA_Reg[63]);
            end
            3'b100: alu_result = DataA_Reg & alu_b;
            3'b101: alu_result = DataA_Reg | alu_b;
            3'b110: alu_result = DataA_Reg ^ alu_b;
            default: alu_result = '0;
        endcase
    end

    assign alu_flags = {alu_result[63], (alu_result == 64'd0), alu_c, alu_v};

    // -------------------------------------------------------------- shifter
    assign shift_result = ShiftDir_Reg ? (DataA_Reg >> SHAMT_Reg)
                                       : (DataA_Reg << SHAMT_Reg);

    // ----------------------------------------------------- multiply control
    // Stall is a function of state and current inputs only; it never looks
    // at the *_Ex registers, so there is no loop through the pipeline.
    always_comb begin
        state_next = state;
        Stall      = 1'b0;
        case (state)
            IDLE: begin
                if (is_mul) begin
                    Stall      = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                Stall = 1'b1;
                if (mul_cnt == 6'd63) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Product is ready; the held instruction is accepted this edge
                // and a following multiply starts only from IDLE.
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            mul_a   <= '0;
            mul_b   <= '0;
            mul_acc <= '0;
            mul_cnt <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (is_mul) begin
                        mul_a   <= DataA_Reg;
                        mul_b   <= DataB_Reg;
                        mul_acc <= '0;
                        mul_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (mul_b[0]) begin
                        mul_acc <= mul_acc + mul_a;
                    end
                    mul_a   <= mul_a << 1;
                    mul_b   <= mul_b >> 1;
                    mul_cnt <= mul_cnt + 6'd1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------- EX/MEM pipeline regs
    always_ff @(posedge clk) begin
        if (reset) begin
            ALU_out_Ex      <= '0;
            shifter2_out_Ex <= '0;
            MUL_out_Ex      <= '0;
            DataB_Ex        <= '0;
            MemWrite_Ex     <= 1'b0;
            MemRead_Ex      <= 1'b0;
            RegWrite_Ex     <= 1'b0;
            RegWrSrc_Ex     <= '0;
            Rd_Ex           <= RD_NONE;
            Flags           <= '0;
        end else if (Stall) begin
            // Bubble: kill all side effects; data buffers and flags hold.
            MemWrite_Ex <= 1'b0;
            MemRead_Ex  <= 1'b0;
            RegWrite_Ex <= 1'b0;
            RegWrSrc_Ex <= '0;
            Rd_Ex       <= RD_NONE;
        end else begin
            ALU_out_Ex      <= alu_result;
            shifter2_out_Ex <= shift_result;
            MUL_out_Ex      <= mul_acc;
            DataB_Ex        <= DataB_Reg;
            MemWrite_Ex     <= MemWrite_Reg;
            MemRead_Ex      <= MemRead_Reg;
            RegWrite_Ex     <= RegWrite_Reg;
            RegWrSrc_Ex     <= RegWrSrc_Reg;
            Rd_Ex           <= Rd_Reg;
            if (SetFlags_Reg) begin
                Flags <= alu_flags;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_ex_stage -- self-checking bench for ex_stage.
// Expected values come from a behavioural model (plain 64-bit arithmetic and
// a software flag register); stall counts are compared against the fixed
// multiply latency.
// -----------------------------------------------------------------------------
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] DataA_Reg, DataB_Reg, Imm_Reg;
    logic        ALUSrc_Reg;
    logic [2:0]  ALUOp_Reg;
    logic [5:0]  SHAMT_Reg;
    logic        ShiftDir_Reg, SetFlags_Reg;
    logic        MemWrite_Reg, MemRead_Reg, RegWrite_Reg;
    logic [1:0]  RegWrSrc_Reg;
    logic [4:0]  Rd_Reg;
    logic [63:0] ALU_out_Ex, shifter2_out_Ex, MUL_out_Ex, DataB_Ex;
    logic        MemWrite_Ex, MemRead_Ex, RegWrite_Ex;
    logic [1:0]  RegWrSrc_Ex;
    logic [4:0]  Rd_Ex;
    logic [3:0]  Flags;
    logic        Stall;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] model_flags;

    typedef struct {
        logic [63:0] a, b, imm;
        logic        src;
        logic [2:0]  op;
        logic [5:0]  shamt;
        logic        dir, sf, mw, mr, rw;
        logic [1:0]  wsrc;
        logic [4:0]  rd;
    } instr_t;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .reset(reset),
        .DataA_Reg(DataA_Reg), .DataB_Reg(DataB_Reg), .Imm_Reg(Imm_Reg),
        .ALUSrc_Reg(ALUSrc_Reg), .ALUOp_Reg(ALUOp_Reg), .SHAMT_Reg(SHAMT_Reg),
        .ShiftDir_Reg(ShiftDir_Reg), .SetFlags_Reg(SetFlags_Reg),
        .MemWrite_Reg(MemWrite_Reg), .MemRead_Reg(MemRead_Reg),
        .RegWrite_Reg(RegWrite_Reg), .RegWrSrc_Reg(RegWrSrc_Reg), .Rd_Reg(Rd_Reg),
        .ALU_out_Ex(ALU_out_Ex), .shifter2_out_Ex(shifter2_out_Ex),
        .MUL_out_Ex(MUL_out_Ex), .DataB_Ex(DataB_Ex),
        .MemWrite_Ex(MemWrite_Ex), .MemRead_Ex(MemRead_Ex),
        .RegWrite_Ex(RegWrite_Ex), .RegWrSrc_Ex(RegWrSrc_Ex), .Rd_Ex(Rd_Ex),
        .Flags(Flags), .Stall(Stall)
    );

    // ------------------------------------------------------ reference model
    function automatic void alu_ref(input logic [63:0] a, input logic [63:0] b,
                                    input logic [2:0] op,
                                    output logic [63:0] res, output logic [3:0] nzcv);
        logic c, v;
        logic signed [65:0] sa, sb, exact, wrapped;
        c  = 1'b0;
        v  = 1'b0;
        sa = $signed({{2{a[63]}}, a});
        sb = $signed({{2{b[63]}}, b});
        case (op)
            3'b000: res = b;
            3'b010: begin
                res     = a + b;
                c       = (res < a);            // unsigned wrap-around
                exact   = sa + sb;
                wrapped = $signed({{2{res[63]}}, res});
                v       = (exact != wrapped);
            end
            3'b011: begin
                res     = a - b;
                c       = (a >= b);             // no borrow
                exact   = sa - sb;
                wrapped = $signed({{2{res[63]}}, res});
                v       = (exact != wrapped);
            end
            3'b100: res = a & b;
            3'b101: res = a | b;
            3'b110: res = a ^ b;
            default: res = 64'd0;
        endcase
        nzcv = {res[63], (res == 64'd0), c, v};
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic instr_t rand_nonmul();
        instr_t t;
        t.a = rand64(); t.b = rand64(); t.imm = rand64();
        t.src = 1'($urandom_range(0, 1));
        t.op = 3'($urandom_range(0, 7));
        t.shamt = 6'($urandom_range(0, 63));
        t.dir = 1'($urandom_range(0, 1));
        t.sf = 1'($urandom_range(0, 1));
        t.mw = 1'($urandom_range(0, 1));
        t.mr = 1'($urandom_range(0, 1));
        t.rw = 1'($urandom_range(0, 1));
        t.wsrc = 2'($urandom_range(0, 3));
        if (t.rw && t.wsrc == 2'b01) t.wsrc = 2'b10;
        t.rd = 5'($urandom_range(0, 30));
        return t;
    endfunction

    function automatic instr_t mk_mul(input logic [63:0] a, input logic [63:0] b,
                                      input logic [4:0] rd);
        instr_t t;
        t = rand_nonmul();
        t.a = a; t.b = b; t.sf = 1'b0; t.mw = 1'b0; t.mr = 1'b0;
        t.rw = 1'b1; t.wsrc = 2'b01; t.rd = rd;
        return t;
    endfunction

    function automatic instr_t mk_alu(input logic [63:0] a, input logic [63:0] b,
                                      input logic [63:0] imm, input logic src,
                                      input logic [2:0] op, input logic sf,
                                      input logic [4:0] rd);
        instr_t t;
        t = rand_nonmul();
        t.a = a; t.b = b; t.imm = imm; t.src = src; t.op = op; t.sf = sf;
        t.rw = 1'b1; t.wsrc = 2'b00; t.rd = rd;
        return t;
    endfunction

    task automatic drive(input instr_t t);
        DataA_Reg = t.a; DataB_Reg = t.b; Imm_Reg = t.imm; ALUSrc_Reg = t.src;
        ALUOp_Reg = t.op; SHAMT_Reg = t.shamt; ShiftDir_Reg = t.dir;
        SetFlags_Reg = t.sf; MemWrite_Reg = t.mw; MemRead_Reg = t.mr;
        RegWrite_Reg = t.rw; RegWrSrc_Reg = t.wsrc; Rd_Reg = t.rd;
    endtask

    // Hold the driven instruction until an edge with Stall low accepts it.
    // Reports the number of stalled edges and whether every stalled edge
    // produced a clean bubble with flags held. Bounded at 200 edges.
    task automatic advance(input logic [3:0] flags_hold,
                           output int stalls, output bit bubbles_ok);
        bit s;
        stalls     = 0;
        bubbles_ok = 1'b1;
        for (int i = 0; i < 200; i++) begin
            #1 s = Stall;
            @(posedge clk);
            #1;
            if (!s) return;
            stalls++;
            if (RegWrite_Ex !== 1'b0 || MemWrite_Ex !== 1'b0 || MemRead_Ex !== 1'b0 ||
                RegWrSrc_Ex !== 2'b00 || Rd_Ex !== 5'd31 || Flags !== flags_hold)
                bubbles_ok = 1'b0;
        end
    endtask

    // ------------------------------------------------------------- tests
    task automatic test_reset();
        instr_t t;
        t = rand_nonmul();
        drive(t);
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++; if (ALU_out_Ex !== 64'd0) begin n_err++; $display("FAIL reset_alu: got %h want 0", ALU_out_Ex); end
        n_cmp++; if (shifter2_out_Ex !== 64'd0) begin n_err++; $display("FAIL reset_shift: got %h want 0", shifter2_out_Ex); end
        n_cmp++; if (MUL_out_Ex !== 64'd0) begin n_err++; $display("FAIL reset_mul: got %h want 0", MUL_out_Ex); end
        n_cmp++; if (DataB_Ex !== 64'd0) begin n_err++; $display("FAIL reset_datab: got %h want 0", DataB_Ex); end
        n_cmp++; if ({MemWrite_Ex, MemRead_Ex, RegWrite_Ex, RegWrSrc_Ex} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 00000", {MemWrite_Ex, MemRead_Ex, RegWrite_Ex, RegWrSrc_Ex}); end
        n_cmp++; if (Rd_Ex !== 5'd31) begin n_err++; $display("FAIL reset_rd: got %0d want 31", Rd_Ex); end
        n_cmp++; if (Flags !== 4'b0) begin n_err++; $display("FAIL reset_flags: got %b want 0000", Flags); end
        n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", Stall); end
        reset = 1'b0;
        model_flags = 4'b0;
    endtask

    task automatic test_alu_directed();
        int st; bit ok;
        drive(mk_alu(64'd5, 64'd7, 64'd0, 1'b0, 3'b010, 1'b1, 5'd4));
        advance(model_flags, st, ok);
        n_cmp++; if (ALU_out_Ex !== 64'd12 || st != 0) begin n_err++; $display("FAIL add_5_7: got %0d stalls %0d want 12 stalls 0", ALU_out_Ex, st); end
        n_cmp++; if (Flags !== 4'b0000) begin n_err++; $display("FAIL add_5_7_flags: got %b want 0000", Flags); end
        drive(mk_alu(64'd7, 64'd7, 64'd0, 1'b0, 3'b011, 1'b1, 5'd5));
        advance(model_flags, st, ok);
        n_cmp++; if (ALU_out_Ex !== 64'd0) begin n_err++; $display("FAIL sub_7_7: got %h want 0", ALU_out_Ex); end
        n_cmp++; if (Flags !== 4'b0110) begin n_err++; $display("FAIL sub_7_7_flags: got %b want 0110", Flags); end
        drive(mk_alu(64'h7FFF_FFFF_FFFF_FFFF, rand64(), 64'd1, 1'b1, 3'b010, 1'b1, 5'd6));
        advance(model_flags, st, ok);
        n_cmp++; if (ALU_out_Ex !== 64'h8000_0000_0000_0000) begin n_err++; $display("FAIL add_ovf: got %h want 8000000000000000", ALU_out_Ex); end
        n_cmp++; if (Flags !== 4'b1001) begin n_err++; $display("FAIL add_ovf_flags: got %b want 1001", Flags); end
        model_flags = 4'b1001;
    endtask

    task automatic test_shifter();
        int st; bit ok; instr_t t; logic [63:0] v;
        t = rand_nonmul(); t.sf = 1'b0;
        t.a = 64'd1; t.shamt = 6'd63; t.dir = 1'b0;
        drive(t); advance(model_flags, st, ok);
        n_cmp++; if (shifter2_out_Ex !== 64'h8000_0000_0000_0000) begin n_err++; $display("FAIL shl63: got %h want 8000000000000000", shifter2_out_Ex); end
        t.a = 64'h8000_0000_0000_0000; t.dir = 1'b1;
        drive(t); advance(model_flags, st, ok);
        n_cmp++; if (shifter2_out_Ex !== 64'd1) begin n_err++; $display("FAIL shr63: got %h want 1", shifter2_out_Ex); end
        v = rand64();
        t.a = v; t.shamt = 6'd0; t.dir = 1'($urandom_range(0, 1));
        drive(t); advance(model_flags, st, ok);
        n_cmp++; if (shifter2_out_Ex !== v) begin n_err++; $display("FAIL shamt0: got %h want %h", shifter2_out_Ex, v); end
        n_cmp++; if (Flags !== model_flags) begin n_err++; $display("FAIL shift_flags_hold: got %b want %b", Flags, model_flags); end
    endtask

    task automatic test_random_alu();
        int st; bit ok; instr_t t; logic [63:0] exp_res, exp_sh, bop; logic [3:0] nz;
        for (int i = 0; i < 40; i++) begin
            t = rand_nonmul();
            if (i % 4 == 0) t.b = t.a;              // exercise Z and no-borrow
            bop = t.src ? t.imm : t.b;
            alu_ref(t.a, bop, t.op, exp_res, nz);
            exp_sh = t.dir ? (t.a / (64'd1 << t.shamt)) : (t.a * (64'd1 << t.shamt));
            if (t.sf) model_flags = nz;
            drive(t);
            advance(Flags, st, ok);
            n_cmp++; if (ALU_out_Ex !== exp_res || st != 0) begin n_err++; $display("FAIL rnd_alu[%0d] op %b: got %h want %h (stalls %0d)", i, t.op, ALU_out_Ex, exp_res, st); end
            n_cmp++; if (shifter2_out_Ex !== exp_sh) begin n_err++; $display("FAIL rnd_shift[%0d]: got %h want %h", i, shifter2_out_Ex, exp_sh); end
            n_cmp++; if (DataB_Ex !== t.b) begin n_err++; $display("FAIL rnd_datab[%0d]: got %h want %h", i, DataB_Ex, t.b); end
            n_cmp++; if ({MemWrite_Ex, MemRead_Ex, RegWrite_Ex, RegWrSrc_Ex, Rd_Ex} !== {t.mw, t.mr, t.rw, t.wsrc, t.rd}) begin
                n_err++; $display("FAIL rnd_ctrl[%0d]: got %b want %b", i, {MemWrite_Ex, MemRead_Ex, RegWrite_Ex, RegWrSrc_Ex, Rd_Ex}, {t.mw, t.mr, t.rw, t.wsrc, t.rd}); end
            n_cmp++; if (Flags !== model_flags) begin n_err++; $display("FAIL rnd_flags[%0d]: got %b want %b", i, Flags, model_flags); end
        end
    endtask

    task automatic test_mul(input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
        int st; bit ok; logic [63:0] exp_p;
        exp_p = a * b;
        drive(mk_mul(a, b, rd));
        advance(model_flags, st, ok);
        n_cmp++; if (st != 65) begin n_err++; $display("FAIL mul_stalls rd%0d: got %0d want 65", rd, st); end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL mul_bubbles rd%0d: got dirty bubble want clean", rd); end
        n_cmp++; if (MUL_out_Ex !== exp_p) begin n_err++; $display("FAIL mul_product rd%0d: got %h want %h", rd, MUL_out_Ex, exp_p); end
        n_cmp++; if ({RegWrite_Ex, RegWrSrc_Ex, Rd_Ex} !== {1'b1, 2'b01, rd}) begin
            n_err++; $display("FAIL mul_ctrl: got %b want %b", {RegWrite_Ex, RegWrSrc_Ex, Rd_Ex}, {1'b1, 2'b01, rd}); end
        n_cmp++; if (Flags !== model_flags) begin n_err++; $display("FAIL mul_flags: got %b want %b", Flags, model_flags); end
    endtask

    task automatic test_reset_mid_mul();
        int st; bit ok; logic [63:0] a, b;
        drive(mk_alu(64'd9, 64'd9, 64'd0, 1'b0, 3'b011, 1'b1, 5'd2));
        advance(model_flags, st, ok);
        model_flags = 4'b0110;
        a = rand64(); b = rand64();
        drive(mk_mul(a, b, 5'd12));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        n_cmp++; if (Stall !== 1'b1) begin n_err++; $display("FAIL midmul_stall: got %b want 1", Stall); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_flags = 4'b0;
        n_cmp++; if ({RegWrite_Ex, RegWrSrc_Ex, Rd_Ex} !== {1'b0, 2'b00, 5'd31}) begin
            n_err++; $display("FAIL midmul_rst_ctrl: got %b want 00011111", {RegWrite_Ex, RegWrSrc_Ex, Rd_Ex}); end
        n_cmp++; if (MUL_out_Ex !== 64'd0 || ALU_out_Ex !== 64'd0) begin
            n_err++; $display("FAIL midmul_rst_data: got mul %h alu %h want 0", MUL_out_Ex, ALU_out_Ex); end
        n_cmp++; if (Flags !== 4'b0) begin n_err++; $display("FAIL midmul_rst_flags: got %b want 0000", Flags); end
        advance(model_flags, st, ok);
        n_cmp++; if (st != 65 || !ok) begin n_err++; $display("FAIL midmul_restart: got stalls %0d clean %0d want 65 1", st, ok); end
        n_cmp++; if (MUL_out_Ex !== a * b || Rd_Ex !== 5'd12) begin
            n_err++; $display("FAIL midmul_product: got %h rd %0d want %h rd 12", MUL_out_Ex, Rd_Ex, a * b); end
    endtask

    task automatic test_back_to_back();
        instr_t q[$];
        int exp_st[$];
        logic [63:0] exp_v[$];
        int st; bit ok;
        q.push_back(mk_mul(64'd2, 64'd3, 5'd1)); exp_st.push_back(65); exp_v.push_back(64'd6);
        q.push_back(mk_mul(64'd4, 64'd5, 5'd2)); exp_st.push_back(65); exp_v.push_back(64'd20);
        q.push_back(mk_alu(64'd1, 64'd1, 64'd0, 1'b0, 3'b010, 1'b0, 5'd3)); exp_st.push_back(0); exp_v.push_back(64'd2);
        foreach (q[i]) begin
            drive(q[i]);
            advance(model_flags, st, ok);
            n_cmp++; if (st != exp_st[i] || !ok) begin n_err++; $display("FAIL b2b_stalls[%0d]: got %0d clean %0d want %0d", i, st, ok, exp_st[i]); end
            n_cmp++; if (Rd_Ex !== q[i].rd || RegWrite_Ex !== 1'b1) begin n_err++; $display("FAIL b2b_rd[%0d]: got %0d want %0d", i, Rd_Ex, q[i].rd); end
            n_cmp++; if ((q[i].wsrc == 2'b01 ? MUL_out_Ex : ALU_out_Ex) !== exp_v[i]) begin
                n_err++; $display("FAIL b2b_value[%0d]: got mul %h alu %h want %h", i, MUL_out_Ex, ALU_out_Ex, exp_v[i]); end
        end
    endtask

    initial begin
        reset = 1'b0;
        model_flags = 4'b0;
        drive(rand_nonmul());
        @(posedge clk); #1;
        test_reset();
        test_alu_directed();
        test_shifter();
        test_random_alu();
        test_mul(64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 5'd9);
        test_mul(rand64(), rand64(), 5'd17);
        test_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0);
        test_reset_mid_mul();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
